// File: rtl/multdiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   state_t     : 2-bit FSM encoding (IDLE, MULT, DIV, DONE)
//   MULT_STEPS  : radix-4 Booth steps for a 32x32 multiply
//   DIV_STEPS   : restoring-divide steps for a 32-bit quotient
//   CNT_W       : step counter width
//   BOOTH_*     : recoder window patterns
//   mag32()     : two's-complement magnitude; 0x80000000 maps to itself
//                 and is read as an unsigned 2^31 by the divider.
package multdiv_defs;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int MULT_STEPS = 16;
  localparam int DIV_STEPS  = 32;
  localparam int CNT_W      = 6;

  // Windows that recode to zero, +2M and -2M; all others are +/-1M.
  localparam logic [2:0] BOOTH_Z0 = 3'b000;
  localparam logic [2:0] BOOTH_Z1 = 3'b111;
  localparam logic [2:0] BOOTH_P2 = 3'b011;
  localparam logic [2:0] BOOTH_M2 = 3'b100;

  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/multdiv_unit_if.sv
// Start/operand/result bundle between the execute stage and multdiv_unit.
//   master : drives ctrl_MULT, ctrl_DIV, data_operandA, data_operandB
//   slave  : drives data_result, data_exception, data_resultRDY
interface multdiv_if #(parameter int WIDTH = 32);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/multdiv_unit_booth4_recoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window to the partial
// product selection {zero, neg, dbl}. Purely combinational.
//   win  : {b[i+1], b[i], b[i-1]}
//   zero : add nothing
//   neg  : subtract the selected multiple
//   dbl  : selected multiple is 2M rather than M
module booth4_recoder
  import multdiv_defs::*;
(
  input  logic [2:0] win,
  output logic       zero,
  output logic       neg,
  output logic       dbl
);
  always_comb begin
    zero = (win == BOOTH_Z0) | (win == BOOTH_Z1);
    neg  = win[2] & ~zero;
    dbl  = (win == BOOTH_P2) | (win == BOOTH_M2);
  end
endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (radix-4 Booth, 16 steps) and divide
// (restoring, 32 steps). A one-cycle ctrl_MULT/ctrl_DIV pulse latches the
// operands; data_resultRDY pulses for one cycle with the result.
//   clock   : rising-edge clock
//   clear_n : synchronous active-low reset
//   bus     : multdiv_if slave (start pulses, operands, result, flags)
module multdiv_unit
  import multdiv_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clock,
  input  logic      clear_n,
  multdiv_if.slave  bus
);
  localparam int W = WIDTH;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [W-1:0]      mcand;
  logic [2*W+1:0]    prod;       // {acc[W:0], multiplier[W-1:0], guard}
  logic [W-1:0]      rem, quo, dvsr;
  logic              q_neg;
  logic [W-1:0]      res_q;
  logic              exc_q;

  logic div_zero, mult_last, div_last;
  assign div_zero  = bus.ctrl_DIV & ~bus.ctrl_MULT & (bus.data_operandB == '0);
  assign mult_last = (cnt == CNT_W'(MULT_STEPS - 1));
  assign div_last  = (cnt == CNT_W'(DIV_STEPS - 1));

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (!clear_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.ctrl_MULT)     state_nxt = S_MULT;
    else if (bus.ctrl_DIV) state_nxt = div_zero ? S_DONE : S_DIV;
    else begin
      case (state)
        S_MULT:  if (mult_last) state_nxt = S_DONE;
        S_DIV:   if (div_last)  state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  // ---------------- Booth step ----------------
  logic         b_zero, b_neg, b_dbl;
  logic [W+1:0] mc_ext, mag, addend, sum;
  logic [2*W+1:0] prod_nxt;
  logic [W-1:0] p_lo, p_hi;
  logic         mult_exc;

  booth4_recoder u_rec (.win(prod[2:0]), .zero(b_zero), .neg(b_neg), .dbl(b_dbl));

  always_comb begin
    mc_ext = {{2{mcand[W-1]}}, mcand};
    mag    = b_dbl ? {mc_ext[W:0], 1'b0} : mc_ext;
    addend = b_zero ? '0 : (b_neg ? (~mag + 1'b1) : mag);
    // Accumulator is widened by one sign bit so +/-2M cannot wrap.
    sum    = {prod[2*W+1], prod[2*W+1:W+1]} + addend;
    // Arithmetic shift right by 2 of {sum, multiplier, guard}.
    prod_nxt = {sum[W+1], sum[W+1:2], sum[1:0], prod[W:2]};
    p_lo     = prod_nxt[W:1];
    p_hi     = prod_nxt[2*W:W+1];
    mult_exc = (p_hi != {W{p_lo[W-1]}});
  end

  // ---------------- Restoring divide step ----------------
  logic [W:0]   trial, diff;
  logic         d_neg;
  logic [W-1:0] rem_nxt, quo_nxt, q_signed;
  logic         div_exc;

  always_comb begin
    // rem < dvsr, so the shifted remainder always fits in W+1 bits.
    trial    = {rem, quo[W-1]};
    diff     = trial - {1'b0, dvsr};
    d_neg    = diff[W];
    rem_nxt  = d_neg ? trial[W-1:0] : diff[W-1:0];
    quo_nxt  = {quo[W-2:0], ~d_neg};
    q_signed = q_neg ? (~quo_nxt + 1'b1) : quo_nxt;
    // A magnitude of 2^31 is only representable as a negative quotient.
    div_exc  = quo_nxt[W-1] & ~q_neg;
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      cnt   <= '0;
      mcand <= '0;
      prod  <= '0;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      q_neg <= 1'b0;
      res_q <= '0;
      exc_q <= 1'b0;
    end else if (bus.ctrl_MULT) begin
      cnt   <= '0;
      mcand <= bus.data_operandA;
      prod  <= {{(W+1){1'b0}}, bus.data_operandB, 1'b0};
    end else if (bus.ctrl_DIV) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= mag32(bus.data_operandA);
      dvsr  <= mag32(bus.data_operandB);
      q_neg <= bus.data_operandA[W-1] ^ bus.data_operandB[W-1];
      if (div_zero) begin
        res_q <= '0;
        exc_q <= 1'b1;
      end
    end else begin
      case (state)
        S_MULT: begin
          prod <= prod_nxt;
          cnt  <= cnt + CNT_W'(1);
          if (mult_last) begin
            res_q <= p_lo;
            exc_q <= mult_exc;
          end
        end
        S_DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + CNT_W'(1);
          if (div_last) begin
            res_q <= q_signed;
            exc_q <= div_exc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.data_result    = res_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = (state == S_DONE);

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: directed operations with literal expectations,
// plus an arithmetic reference model checked every cycle.
module tb_multdiv_unit;
  logic clock = 1'b0;
  logic clear_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  multdiv_if #(.WIDTH(32)) bus ();
  multdiv_unit #(.WIDTH(32)) dut (.clock(clock), .clear_n(clear_n), .bus(bus));

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  bit          m_known = 0, m_rdy = 0, m_pend = 0, m_zero = 0;
  int          m_rem = 0;
  logic [31:0] m_res = '0, e_res = '0;
  logic        m_exc = 1'b0, e_exc = 1'b0;

  function automatic void model_op(input bit is_mult, input int a, input int b,
                                   output logic [31:0] r, output logic x);
    longint p;
    int     q;
    if (is_mult) begin
      p = longint'(a) * longint'(b);
      r = p[31:0];
      x = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (b == 0) begin
      r = 32'h0; x = 1'b1;
    end else if (a == 32'sh80000000 && b == -1) begin
      r = 32'h80000000; x = 1'b1;
    end else begin
      q = a / b;
      r = q; x = 1'b0;
    end
  endfunction

  always @(posedge clock) begin
    m_rdy = 0;
    if (!clear_n) begin
      m_known = 1; m_pend = 0; m_zero = 1; m_res = '0; m_exc = 1'b0;
    end else if (bus.ctrl_MULT || bus.ctrl_DIV) begin
      model_op(bus.ctrl_MULT, bus.data_operandA, bus.data_operandB, e_res, e_exc);
      m_rem  = bus.ctrl_MULT ? 16 : ((bus.data_operandB == 32'h0) ? 0 : 32);
      m_pend = 1;
    end else if (m_pend) begin
      m_rem = m_rem - 1;
    end
    if (clear_n && m_pend && m_rem == 0) begin
      m_rdy = 1; m_pend = 0; m_zero = 0; m_res = e_res; m_exc = e_exc;
    end
  end

  always @(negedge clock) begin
    if (m_known) begin
      total++;
      if (bus.data_resultRDY !== m_rdy) begin
        bad++;
        $display("FAIL model_rdy t=%0t act=%b exp=%b", $time, bus.data_resultRDY, m_rdy);
      end
      if (m_rdy || m_zero) begin
        total++;
        if (bus.data_result !== m_res) begin
          bad++;
          $display("FAIL model_result t=%0t act=%h exp=%h", $time, bus.data_result, m_res);
        end
        total++;
        if (bus.data_exception !== m_exc) begin
          bad++;
          $display("FAIL model_exc t=%0t act=%b exp=%b", $time, bus.data_exception, m_exc);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; the following posedge is the start edge.
  task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_MULT = m;
    bus.ctrl_DIV = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = 32'hDEADBEEF;
    bus.data_operandB = 32'h0BADF00D;
  endtask

  // Returns at the negedge where RDY is seen (or after the bound expires).
  task automatic wait_rdy(input string name, input int exp_lat,
                          input logic [31:0] lit_res, input logic lit_exc);
    int lat = 0;
    while (bus.data_resultRDY !== 1'b1 && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_res"}, bus.data_result, lit_res);
    check({name, "_exc"}, {31'b0, bus.data_exception}, {31'b0, lit_exc});
  endtask

  initial begin
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    clear_n = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_rdy", {31'b0, bus.data_resultRDY}, 32'd0);
    check("reset_res", bus.data_result, 32'd0);
    check("reset_exc", {31'b0, bus.data_exception}, 32'd0);
    clear_n = 1'b1;

    @(negedge clock); start_op(1, 0, 32'd7, -32'sd3);
    wait_rdy("mul_7_m3", 16, 32'hFFFFFFEB, 1'b0);
    @(negedge clock); start_op(1, 0, 32'h00010000, 32'h00010000);
    wait_rdy("mul_ovf", 16, 32'h00000000, 1'b1);
    @(negedge clock); start_op(1, 0, 32'h80000000, 32'd1);
    wait_rdy("mul_min", 16, 32'h80000000, 1'b0);
    @(negedge clock); start_op(0, 1, -32'sd100, 32'd7);
    wait_rdy("div_m100_7", 32, 32'hFFFFFFF2, 1'b0);
    @(negedge clock); start_op(0, 1, 32'd5, 32'd0);
    wait_rdy("div_zero", 0, 32'h00000000, 1'b1);
    @(negedge clock); start_op(0, 1, 32'h80000000, 32'hFFFFFFFF);
    wait_rdy("div_ovf", 32, 32'h80000000, 1'b1);

    // Divide aborted by a multiply at edge 10; only the multiply completes.
    @(negedge clock); start_op(0, 1, 32'd1000, 32'd3);
    repeat (9) @(negedge clock);
    start_op(1, 0, 32'd6, 32'd6);
    wait_rdy("restart", 16, 32'd36, 1'b0);
    repeat (40) @(negedge clock);

    // Reset at edge 8 of a multiply.
    @(negedge clock); start_op(1, 0, 32'd9, 32'd9);
    repeat (7) @(negedge clock);
    clear_n = 1'b0;
    @(negedge clock);
    clear_n = 1'b1;
    check("midrst_rdy", {31'b0, bus.data_resultRDY}, 32'd0);
    check("midrst_res", bus.data_result, 32'd0);
    check("midrst_exc", {31'b0, bus.data_exception}, 32'd0);
    repeat (25) @(negedge clock);
    check("midrst_norydy", {31'b0, bus.data_resultRDY}, 32'd0);

    // Both starts together, then back-to-back start in the RDY cycle.
    @(negedge clock); start_op(1, 1, 32'd3, 32'd4);
    wait_rdy("both", 16, 32'd12, 1'b0);
    start_op(1, 0, -32'sd5, 32'd6);
    wait_rdy("b2b", 16, 32'hFFFFFFE2, 1'b0);
    repeat (3) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
